snake_body_ctrl: RTL
====================

# snake_body_ctrl

Snake movement and body controller for the Snake game. Steps the head once per move tick in the latched direction and keeps the ordered body segment list. Grows on the eat pulse from the food generator and ends the game on wall, self or poison collision. Drives the head coordinates back to the food generator and answers per-cell body-occupancy queries from the VGA renderer.

## Interface
- STEP_DIV, 12_500_000: clocks per move step (0.5 s at 25 MHz); minimum 4.
- MAX_LEN, 16: maximum segment count, 3..63.
- X_MAX, 39: right wall column; playfield columns are 1..X_MAX-1.
- Y_MAX, 29: bottom wall row; playfield rows are 1..Y_MAX-1.

- clk  in  1  system clock, 25 MHz.
- rst  in  1  synchronous, active-high reset.
- key_dir  in  4  debounced direction keys {up,down,left,right}, level.
- add_cube  in  1  one-cycle pulse: apple eaten.
- died  in  1  one-cycle pulse: poison eaten.
- head_x  out  6  head column.
- head_y  out  6  head row; upper bit always 0.
- query_x  in  6  renderer cell column.
- query_y  in  5  renderer cell row.
- query_hit  out  1  queried cell holds a body or head segment; registered.
- length  out  6  current segment count.
- game_over  out  1  high in DEAD.
- running  out  1  high in RUN.

## Operation
- Body storage is MAX_LEN (x,y) registers, and seg[0] is the head. A move shifts seg[i] into seg[i+1] and writes the new head into seg[0].
- Initial snake: seg0=(20,15), seg1=(19,15), seg2=(18,15), length=3, direction right.
- States:
  - IDLE: snake at its initial position, no motion. Any nonzero key_dir goes to RUN.
  - RUN: moves on every tick.
  - DEAD: position frozen. A nonzero key_dir with the tick counter at 0 goes to IDLE and reloads the initial snake.
- Direction: key priority is up > down > left > right. A key that reverses the current direction is ignored. The new direction is latched into pending_dir and applied at the next move.
- Move on tick in RUN:
  - Compute next = head + unit(pending_dir).
  - grow = grow_pending | add_cube.
- Collision checks, in order:
  - Wall: next_x ∈ {0, X_MAX} or next_y ∈ {0, Y_MAX} → DEAD, no shift.
  - Self: next equals any seg[i] with i < length-1. When grow is set, the range extends to i < length. A match → DEAD, no shift.
- Otherwise the shift occurs. If grow and length < MAX_LEN, length increments; at MAX_LEN the growth is dropped. grow_pending clears.
- add_cube outside a tick sets grow_pending. Further pulses before the next tick do not stack.
- A died pulse in RUN goes to DEAD on the next edge, regardless of tick.
- query_hit = OR over i < length of (seg[i] == query), registered. It is valid in every state.

## Timing
- Reset values:
  - head_x=20, head_y=15, length=3.
  - game_over=0, running=0, query_hit=0.
  - State IDLE, tick counter 0, grow_pending=0, pending_dir=right.
- Tick counter runs only in RUN. It counts 0..STEP_DIV-1, and tick is asserted at STEP_DIV-1. On entry to RUN the counter is 0, so the first move lands STEP_DIV cycles after entry.
- head_x/head_y and length update on the same edge as the tick. game_over rises on that edge too when a collision is detected.
- died to game_over latency is 1 clock.
- query_x/y to query_hit latency is 1 clock.
- add_cube and tick in the same cycle: the growth applies to that move.
- died and tick in the same cycle: DEAD, no shift.
- rst mid-game restores all reset values on the next edge.

## Configuration
- SNAKE_WRAP_EN defined: walls do not kill.
  - next_x=0 becomes X_MAX-1; next_x=X_MAX becomes 1.
  - Y wraps the same way with Y_MAX.
  - The self and poison checks are unchanged.
- Undefined: wall collision goes to DEAD as specified above.

## Test plan
All scenarios run with STEP_DIV=4.
- Reset, press right, wait 4 clocks → head (21,15), length 3. After 4 more clocks → (22,15).
- Heading right, press left then up within one step → left ignored. Next move gives head_y=14, head_x unchanged.
- Pulse add_cube mid-step → length 3→4 at the next tick, tail kept. A second pulse before that tick → still 4.
- Run right from (20,15) → head reaches (38,15), and the next tick gives game_over=1 with the head frozen at (38,15). With SNAKE_WRAP_EN the head goes to (1,15) instead.
- Grow to length 5 and drive up/left/down into the body → game_over=1 on the colliding tick.
- Pulse died in RUN → game_over=1 one clock later. A key in DEAD → IDLE with the initial snake. query (19,15) → query_hit=1 next cycle; query (5,5) → 0.

Source files
------------

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl
//   Snake movement and body controller. Steps the head once per move tick in
//   the latched direction, keeps the ordered segment list (seg[0] is the head),
//   grows on apple pulses, and ends the game on wall, self or poison collision.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   key_dir    {up,down,left,right} level keys, priority up > down > left > right
//   add_cube   one-cycle pulse: apple eaten
//   died       one-cycle pulse: poison eaten
//   head_x/y   head coordinates (head_y upper bit always 0)
//   query_x/y  renderer cell to test for body occupancy
//   query_hit  registered: queried cell holds a live segment
//   length     current segment count
//   game_over  high in DEAD
//   running    high in RUN
//
// Configuration
//   SNAKE_WRAP_EN  when defined the playfield wraps at the walls instead of
//                  killing the snake; self and poison checks are unchanged.
module snake_body_ctrl #(
  parameter int STEP_DIV = 12_500_000,
  parameter int MAX_LEN  = 16,
  parameter int X_MAX    = 39,
  parameter int Y_MAX    = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_dir,
  input  logic       add_cube,
  input  logic       died,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  input  logic [5:0] query_x,
  input  logic [4:0] query_y,
  output logic       query_hit,
  output logic [5:0] length,
  output logic       game_over,
  output logic       running
);

  localparam int         CW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [5:0] X_LIM   = 6'(X_MAX);
  localparam logic [5:0] Y_LIM   = 6'(Y_MAX);
  localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } pos_t;

  function automatic dir_t opposite(dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

  // Starting snake: three segments in a row, head at (20,15), facing right.
  function automatic pos_t init_seg(int i);
    if (i < 3) return '{x: 6'(20 - i), y: 6'd15};
    return '0;
  endfunction

  state_t        state;
  dir_t          cur_dir;      // direction of the last applied move
  dir_t          pending_dir;  // direction the next move will use
  pos_t          seg [MAX_LEN];
  logic [CW-1:0] tick_cnt;
  logic          grow_pending;

  logic          tick;
  logic          key_valid;
  logic          key_ok;
  dir_t          key_sel;
  dir_t          ref_dir;
  pos_t          nxt;
  pos_t          query;
  logic          wall_hit;
  logic          self_hit;
  logic          grow;
  logic [5:0]    self_limit;
  logic          hit_c;

  assign tick   = (state == RUN) && (tick_cnt == CW'(STEP_DIV - 1));
  assign head_x = seg[0].x;
  assign head_y = seg[0].y;
  assign query  = {query_x, 1'b0, query_y};

  // Reversal is judged against the direction the snake will actually be
  // travelling after this edge, so a key landing on the tick edge cannot
  // fold the head back onto the neck at the following move.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    key_valid = |key_dir;
    key_sel   = DIR_RIGHT;
    if (key_dir[3])      key_sel = DIR_UP;
    else if (key_dir[2]) key_sel = DIR_DOWN;
    else if (key_dir[1]) key_sel = DIR_LEFT;
    ref_dir = tick ? pending_dir : cur_dir;
    key_ok  = key_valid && (key_sel != opposite(ref_dir));
  end

  // Candidate head position and collision checks for the next move.
  always_comb begin
    nxt = seg[0];
    case (pending_dir)
      DIR_UP:   nxt.y = seg[0].y - 6'd1;
      DIR_DOWN: nxt.y = seg[0].y + 6'd1;
      DIR_LEFT: nxt.x = seg[0].x - 6'd1;
      default:  nxt.x = seg[0].x + 6'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
    if (nxt.x == '0)         nxt.x = X_LIM - 6'd1;
    else if (nxt.x == X_LIM) nxt.x = 6'd1;
    if (nxt.y == '0)         nxt.y = Y_LIM - 6'd1;
    else if (nxt.y == Y_LIM) nxt.y = 6'd1;
`else
    wall_hit = (nxt.x == '0) || (nxt.x == X_LIM) || (nxt.y == '0) || (nxt.y == Y_LIM);
`endif
    grow = grow_pending | add_cube;
    // Without growth the tail vacates its cell on this move, so it is exempt.
    self_limit = grow ? length : length - 6'd1;
    self_hit   = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((6'(i) < self_limit) && (seg[i] == nxt)) self_hit = 1'b1;
  end

  always_comb begin
    hit_c = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((6'(i) < length) && (seg[i] == query)) hit_c = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur_dir      <= DIR_RIGHT;
      pending_dir  <= DIR_RIGHT;
      tick_cnt     <= '0;
      grow_pending <= 1'b0;
      length       <= 6'd3;
      game_over    <= 1'b0;
      running      <= 1'b0;
      query_hit    <= 1'b0;
      // NOTE: the whole segment array is reset, not just the live entries, so growth never shifts in X values.
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
    end else begin
      query_hit <= hit_c;
      case (state)
        IDLE: begin
          if (key_ok) pending_dir <= key_sel;
          if (key_valid) begin
            state    <= RUN;
            running  <= 1'b1;
            tick_cnt <= '0;
          end
        end

        RUN: begin
          if (key_ok) pending_dir <= key_sel;
          tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
          if (died) begin
            state     <= DEAD;
            running   <= 1'b0;
            game_over <= 1'b1;
            tick_cnt  <= '0;
          end else if (tick) begin
            grow_pending <= 1'b0;
            if (wall_hit || self_hit) begin
              state     <= DEAD;
              running   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
              seg[0]  <= nxt;
              cur_dir <= pending_dir;
              // At full length the shift drops the tail, so growth is lost.
              if (grow && (length < LEN_MAX)) length <= length + 6'd1;
            end
          end else if (add_cube) begin
            grow_pending <= 1'b1;
          end
        end

        DEAD: begin
          tick_cnt <= '0;
          if (key_valid && (tick_cnt == '0)) begin
            state        <= IDLE;
            game_over    <= 1'b0;
            cur_dir      <= DIR_RIGHT;
            pending_dir  <= DIR_RIGHT;
            grow_pending <= 1'b0;
            length       <= 6'd3;
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
          end
        end

        default: begin
          state     <= IDLE;
          running   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
